// File: rtl/imem_axil_responder.sv
// AXI4-Lite read-channel responder for the icache memory port.
// Requests are queued in order, each waits READ_LATENCY cycles, and then
// one 32-bit word is returned from an on-chip array with an AXI response.
// The array is preloaded through a side-band write port and is never reset.
module imem_axil_responder #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            MEM_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned            READ_LATENCY = 1,
    parameter int unsigned            QUEUE_DEPTH  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         s_arvalid_i,
    output logic                         s_arready_o,
    input  logic [ADDR_WIDTH-1:0]        s_araddr_i,
    output logic                         s_rvalid_o,
    input  logic                         s_rready_i,
    output logic [31:0]                  s_rdata_o,
    output logic [1:0]                   s_rresp_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                  init_wdata_i
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0]    OCC_FULL = OCC_W'(QUEUE_DEPTH);
    localparam logic [3:0]          CNT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   load_resp;

    logic [ADDR_WIDTH-1:0]  queue_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]       occ_q, occ_next;
    logic                   push, pop;

    logic [31:0]            mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [ADDR_WIDTH-1:0]  offset;
    logic                   in_range;
    logic [IDX_W-1:0]       word_idx;

    // Ready comes from registered occupancy only; a pop in the same cycle
    // does not open a slot for the incoming request.
    assign s_arready_o = (occ_q != OCC_FULL);
    assign push        = s_arvalid_i && s_arready_o;
    assign pop         = (state_q == ST_RESP) && s_rready_i;
    assign occ_next    = occ_q + OCC_W'(push) - OCC_W'(pop);

    // Decode the head request relative to the base of the array; the
    // subtraction wraps so addresses below the base land out of range.
    assign head_addr = queue_q[rd_ptr_q];
    assign offset    = head_addr - BASE_ADDR;
    assign in_range  = ({1'b0, offset} < SPAN);
    assign word_idx  = offset[IDX_W+1:2];

    // Request queue storage and preload port: plain storage without reset.
    // NOTE: storage arrays are left out of the reset so they map onto RAM;
    // the occupancy and pointers below decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            queue_q[wr_ptr_q] <= s_araddr_i;
        end
        if (init_we_i) begin
            mem[init_addr_i] <= init_wdata_i;
        end
    end

    // Queue pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_next;
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: wait out the latency, present, then hold for R.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (occ_q != '0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    load_resp = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_rready_i) begin
                    if (occ_next != '0) begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers: captured once per request, held until handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= '0;
            s_rresp_o  <= RESP_OKAY;
        end else if (load_resp) begin
            s_rvalid_o <= 1'b1;
            s_rdata_o  <= in_range ? mem[word_idx] : 32'h0;
            s_rresp_o  <= in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (pop) begin
            s_rvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_axil_responder.sv
// Directed bench for imem_axil_responder: reset state, a table of single
// reads (in-range, unaligned, out-of-range), a line-fill burst, R stall with
// a concurrent preload write, and reset in the middle of a latency wait.
module tb_imem_axil_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (READ_LATENCY = 1)
    logic        rst_n, arvalid, arready, rvalid, rready, init_we;
    logic [31:0] araddr, rdata, init_wdata;
    logic [1:0]  rresp;
    logic [9:0]  init_addr;

    // Second instance with READ_LATENCY = 3 for the reset-in-WAIT case
    logic        rst3_n, arvalid3, arready3, rvalid3, rready3, init_we3;
    logic [31:0] araddr3, rdata3, init_wdata3;
    logic [1:0]  rresp3;
    logic [9:0]  init_addr3;

    imem_axil_responder u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_arvalid_i(arvalid), .s_arready_o(arready), .s_araddr_i(araddr),
        .s_rvalid_o(rvalid), .s_rready_i(rready), .s_rdata_o(rdata), .s_rresp_o(rresp),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_wdata_i(init_wdata)
    );

    imem_axil_responder #(.READ_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst3_n),
        .s_arvalid_i(arvalid3), .s_arready_o(arready3), .s_araddr_i(araddr3),
        .s_rvalid_o(rvalid3), .s_rready_i(rready3), .s_rdata_o(rdata3), .s_rresp_o(rresp3),
        .init_we_i(init_we3), .init_addr_i(init_addr3), .init_wdata_i(init_wdata3)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        init_we = 1'b1; init_addr = idx; init_wdata = data;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // One read on the default instance with rready held high. lat counts
    // rising edges after the AR handshake edge until rvalid is seen.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] d,
                           output logic [1:0] r, output int lat, output logic rv_after);
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = rdata; r = rresp;
        @(negedge clk);
        rv_after = rvalid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        logic        rv_after;
        logic [31:0] got_d [8];
        logic [1:0]  got_r [8];
        int          n_got;
        bit          saw_full;
        int          stale;

        rst_n = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b1;
        init_we = 1'b0; init_addr = '0; init_wdata = '0;
        rst3_n = 1'b0; arvalid3 = 1'b0; araddr3 = '0; rready3 = 1'b1;
        init_we3 = 1'b0; init_addr3 = '0; init_wdata3 = '0;

        // ---- reset state ----
        @(negedge clk);
        check("reset arready", 32'(arready), 32'd1);
        check("reset rvalid",  32'(rvalid),  32'd0);
        check("reset rdata",   rdata,        32'd0);
        check("reset rresp",   32'(rresp),   32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;

        // ---- preload ----
        for (int i = 0; i < 16; i++) preload(10'(i), 32'(i));
        preload(10'd5, 32'hDEAD_BEEF);
        preload(10'd1023, 32'hA5A5_0FFF);

        // ---- table-driven single reads (latency 2 each) ----
        vecs[0] = '{32'h0000_0014, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h0000_0020, 32'd8,         2'b00};
        vecs[2] = '{32'h0000_003F, 32'd15,        2'b00};  // low bits ignored
        vecs[3] = '{32'h0000_1000, 32'd0,         2'b10};  // one past the end
        vecs[4] = '{32'hFFFF_FFFC, 32'd0,         2'b10};  // below base
        vecs[5] = '{32'h0000_000C, 32'd3,         2'b00};  // recovery after errors
        vecs[6] = '{32'h0000_0FFC, 32'hA5A5_0FFF, 2'b00};  // last word
        vecs[7] = '{32'h0000_1004, 32'd0,         2'b10};
        vecs[8] = '{32'h8000_0000, 32'd0,         2'b10};
        for (int i = 0; i < 9; i++) begin
            do_read(vecs[i].addr, d, r, lat, rv_after);
            check($sformatf("vec%0d rdata", i),   d,          vecs[i].data);
            check($sformatf("vec%0d rresp", i),   32'(r),     32'(vecs[i].resp));
            check($sformatf("vec%0d latency", i), 32'(lat),   32'd2);
            check($sformatf("vec%0d rvalid after", i), 32'(rv_after), 32'd0);
        end

        // ---- line-fill burst: 8 ARs to 0x20..0x3C ----
        saw_full = 1'b0;
        n_got = 0;
        rready = 1'b1;
        fork
            begin : producer
                int w;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    arvalid = 1'b1; araddr = 32'h20 + 32'(4 * i);
                    w = 0;
                    while (!arready && w < 100) begin
                        saw_full = 1'b1;
                        @(negedge clk);
                        w++;
                    end
                end
                @(negedge clk);
                arvalid = 1'b0;
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (n_got < 8 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (rvalid) begin
                        got_d[n_got] = rdata;
                        got_r[n_got] = rresp;
                        n_got++;
                    end
                end
            end
        join
        check("burst arready dropped", 32'(saw_full), 32'd1);
        check("burst response count", 32'(n_got), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < n_got) begin
                check($sformatf("burst%0d rdata", i), got_d[i], 32'(8 + i));
                check($sformatf("burst%0d rresp", i), 32'(got_r[i]), 32'd0);
            end
        end
        repeat (3) @(negedge clk);
        check("burst queue drained", 32'(rvalid), 32'd0);

        // ---- backpressure with concurrent preload write ----
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h14;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("stall rvalid seen", 32'(rvalid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d rvalid", k), 32'(rvalid), 32'd1);
            check($sformatf("stall%0d rdata", k),  rdata,        32'hDEAD_BEEF);
            check($sformatf("stall%0d rresp", k),  32'(rresp),   32'd0);
            init_we = (k == 1); init_addr = 10'd5; init_wdata = 32'h1234_5678;
            @(negedge clk);
        end
        init_we = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        check("stall handshake rvalid", 32'(rvalid), 32'd0);
        do_read(32'h14, d, r, lat, rv_after);
        check("post-stall new data", d, 32'h1234_5678);

        // ---- async reset drops a pending response ----
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h20;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("pre-reset rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset rvalid", 32'(rvalid), 32'd0);
        check("async reset rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        do_read(32'h14, d, r, lat, rv_after);
        check("memory kept over reset", d, 32'h1234_5678);
        check("read after reset latency", 32'(lat), 32'd2);

        // ---- reset during WAIT with READ_LATENCY = 3 ----
        @(negedge clk);
        init_we3 = 1'b1; init_addr3 = 10'd2; init_wdata3 = 32'hCAFE_0002;
        @(negedge clk);
        init_we3 = 1'b1; init_addr3 = 10'd3; init_wdata3 = 32'hCAFE_0003;
        @(negedge clk);
        init_we3 = 1'b0;
        arvalid3 = 1'b1; araddr3 = 32'h8;
        @(negedge clk);
        araddr3 = 32'hC;
        @(negedge clk);
        arvalid3 = 1'b0;
        @(negedge clk);              // FSM is mid-WAIT here
        check("L3 still waiting", 32'(rvalid3), 32'd0);
        rst3_n = 1'b0;
        #1;
        check("L3 reset rvalid", 32'(rvalid3), 32'd0);
        repeat (2) @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        check("L3 arready after release", 32'(arready3), 32'd1);
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rvalid3) stale++;
        end
        check("L3 no stale response", 32'(stale), 32'd0);

        arvalid3 = 1'b1; araddr3 = 32'h8; rready3 = 1'b1;
        @(negedge clk);
        arvalid3 = 1'b0;
        lat = 0;
        while (!rvalid3 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("L3 fresh latency", 32'(lat), 32'd4);
        check("L3 fresh rdata", rdata3, 32'hCAFE_0002);
        check("L3 fresh rresp", 32'(rresp3), 32'd0);
        @(negedge clk);
        check("L3 rvalid after handshake", 32'(rvalid3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
